// File: rtl/snake_pkg.sv
// Shared VGA timing constants for the draw pipeline: 800x600 at 40 MHz.
// Latency: none (constants only).
// Backpressure: none.
// Contents: default H/V porch and sync widths, derived line/frame totals, and
// the counter width shared with vga_if.
package snake_pkg;

   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FP     = 40;
   localparam int DEF_H_SYNC   = 128;
   localparam int DEF_H_BP     = 88;

   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 1;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 23;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 1056
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 628

   localparam int VGA_CNT_W = 11;

endpackage

// File: rtl/vga_if.sv
// Pixel-timing bundle consumed by every draw_* stage.
// Latency: none (wires only).
// Backpressure: none; timing is free-running from the source.
// Fields: hcount/vcount pixel position, hsync/vsync active-high syncs,
// hblnk/vblnk blanking strobes. Modport out = timing source, in = draw stage.
interface vga_if;
   import snake_pkg::*;

   logic [VGA_CNT_W-1:0] hcount;
   logic                 hsync;
   logic                 hblnk;
   logic [VGA_CNT_W-1:0] vcount;
   logic                 vsync;
   logic                 vblnk;

   modport out (output hcount, hsync, hblnk, vcount, vsync, vblnk);
   modport in  (input  hcount, hsync, hblnk, vcount, vsync, vblnk);

endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with enable; exposes the post-edge value combinationally.
// Latency: cnt updates on the enabled clk edge; nxt/wrap are same-cycle.
// Backpressure: none; holds when en is low.
// Ports: clk, rst (async active-low), en; cnt (registered count),
// nxt (value cnt takes at the next edge), wrap (en high at MOD-1).
module mod_counter #(
   parameter int MOD = 16,
   parameter int W   = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic [W-1:0] nxt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   assign wrap = en && (cnt == LAST);

   always_comb begin
      nxt = cnt;
      if (en) begin
         nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else begin
         cnt <= nxt;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: h/v counters, sync/blank strobes, frame pulse and frame counter.
// Latency: all outputs are flops, updated on clk edges with pix_en high.
// Backpressure: none; pix_en low freezes every output and forces frame_start low.
// Ports: clk, rst (async active-low), pix_en; vga_out (vga_if.out timing bundle),
// frame_start (one-cycle pulse on entering (0,0) after a wrap), frame_cnt (frames mod 2^W).
module vga_timing_gen
   import snake_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter int FRAME_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pix_en,
   vga_if.out                     vga_out,
   output logic                   frame_start,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [VGA_CNT_W-1:0] HB_START = VGA_CNT_W'(H_ACTIVE);
   localparam logic [VGA_CNT_W-1:0] HS_START = VGA_CNT_W'(H_ACTIVE + H_FP);
   localparam logic [VGA_CNT_W-1:0] HS_END   = VGA_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VGA_CNT_W-1:0] VB_START = VGA_CNT_W'(V_ACTIVE);
   localparam logic [VGA_CNT_W-1:0] VS_START = VGA_CNT_W'(V_ACTIVE + V_FP);
   localparam logic [VGA_CNT_W-1:0] VS_END   = VGA_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
      $error("vga_timing_gen: every porch and sync width must be >= 1");
   end
   if (H_TOT > (1 << VGA_CNT_W) || V_TOT > (1 << VGA_CNT_W)) begin : g_bad_total
      $error("vga_timing_gen: line/frame total exceeds counter width");
   end

   logic [VGA_CNT_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
   logic                 h_wrap, v_wrap;

   mod_counter #(.MOD(H_TOT), .W(VGA_CNT_W)) u_hcnt (
      .clk  (clk),
      .rst  (rst),
      .en   (pix_en),
      .cnt  (h_cnt),
      .nxt  (h_nxt),
      .wrap (h_wrap)
   );

   // The vertical counter steps only on the enabled edge that ends a line.
   mod_counter #(.MOD(V_TOT), .W(VGA_CNT_W)) u_vcnt (
      .clk  (clk),
      .rst  (rst),
      .en   (h_wrap),
      .cnt  (v_cnt),
      .nxt  (v_nxt),
      .wrap (v_wrap)
   );

   logic hsync_q, hblnk_q, vsync_q, vblnk_q;

   // Strobes are decoded from the post-edge counts so they land in the same
   // cycle as the counts they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsync_q     <= 1'b0;
         hblnk_q     <= 1'b0;
         vsync_q     <= 1'b0;
         vblnk_q     <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else if (pix_en) begin
         hsync_q     <= (h_nxt >= HS_START) && (h_nxt < HS_END);
         hblnk_q     <= (h_nxt >= HB_START);
         vsync_q     <= (v_nxt >= VS_START) && (v_nxt < VS_END);
         vblnk_q     <= (v_nxt >= VB_START);
         // v_wrap implies h_wrap and pix_en: this edge lands on (0,0) from the last pixel.
         frame_start <= v_wrap;
         if (v_wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end else begin
         frame_start <= 1'b0;
      end
   end

   assign vga_out.hcount = h_cnt;
   assign vga_out.vcount = v_cnt;
   assign vga_out.hsync  = hsync_q;
   assign vga_out.hblnk  = hblnk_q;
   assign vga_out.vsync  = vsync_q;
   assign vga_out.vblnk  = vblnk_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Source of the `vga_if` pixel-timing bundle that every `draw_*` stage in the display chain consumes. It generates the horizontal and vertical counters, sync and blanking strobes for an 800x600 frame, plus a start-of-frame pulse and a wrapping frame counter used for blink and animation timing. It sits at the head of the draw pipeline, ahead of the background, board, menu and error overlays.

## Interface
Parameters:
- `H_ACTIVE`, default 800: visible pixels per line.
- `H_FP`, default 40: horizontal front porch, in pixels.
- `H_SYNC`, default 128: hsync width, in pixels.
- `H_BP`, default 88: horizontal back porch, in pixels.
- `V_ACTIVE`, default 600: visible lines per frame.
- `V_FP`, default 1: vertical front porch, in lines.
- `V_SYNC`, default 4: vsync width, in lines.
- `V_BP`, default 23: vertical back porch, in lines.
- `FRAME_CNT_W`, default 8: width of `frame_cnt`.

Ports:
- `clk`, in, 1: pixel-domain clock, 40 MHz.
- `rst`, in, 1: asynchronous, active-low reset.
- `pix_en`, in, 1: pixel-clock enable. Counters advance only when it is high. Tie it to 1 for a native 40 MHz clock.
- `vga_out`, `vga_if.out`: carries `hcount[10:0]`, `hsync`, `hblnk`, `vcount[10:0]`, `vsync`, `vblnk`.
- `frame_start`, out, 1: one-cycle pulse at pixel (0,0).
- `frame_cnt`, out, `FRAME_CNT_W`: number of completed frames, modulo 2^W.

## Operation
- Line and frame totals:
  - `H_TOTAL` = sum of the four H parameters = 1056.
  - `V_TOTAL` = sum of the four V parameters = 628.
- `hcount` advances 0 … H_TOTAL-1, then wraps to 0. On that wrap, `vcount` advances 0 … V_TOTAL-1, then wraps to 0.
- Counters change only on a `clk` edge with `pix_en`=1. With `pix_en`=0 every output holds, and `frame_start` is 0.
- Horizontal strobes:
  - `hblnk` = 1 for `hcount` >= H_ACTIVE.
  - `hsync` = 1 for H_ACTIVE+H_FP <= `hcount` < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967.
- Vertical strobes:
  - `vblnk` = 1 for `vcount` >= V_ACTIVE.
  - `vsync` = 1 for 601 <= `vcount` <= 604.
- Sync polarity is active-high, as all `draw_*` stages expect.
- Every output is a flop. Sync and blank are decoded from the next count values, so they are aligned with `hcount`/`vcount` in the same cycle. There is no skew between fields.
- `frame_start` is high for exactly one enabled cycle, when the outputs present (0,0) after a wrap. It is not asserted on the first frame out of reset.
- `frame_cnt` increments in the same cycle `frame_start` asserts and wraps from 2^W-1 to 0.
- Required parameter constraint: every porch and sync width is >= 1. An elaboration-time check flags violations.

## Timing
- Reset values:
  - `hcount`=0, `vcount`=0.
  - `hsync`=0, `vsync`=0, `hblnk`=0, `vblnk`=0.
  - `frame_start`=0, `frame_cnt`=0.
- On the first enabled edge after reset release, `hcount` becomes 1.
- Reset asserted mid-line or mid-frame clears everything asynchronously; there is no partial-frame recovery.
- Line period is 1056 enabled cycles; frame period is 1056×628 = 663168 enabled cycles.
- End-of-frame boundary: at `hcount`=1055 with `vcount`=627, the next enabled edge produces `hcount`=0, `vcount`=0, `frame_start`=1 and `frame_cnt`+1, all in one cycle.
- End-of-line boundary: at `hcount`=1055 with any other `vcount`, `hcount` goes to 0 and `vcount`+1; `hblnk` falls in that same cycle.
- Downstream latency is the responsibility of each `draw_*` stage. This block adds none beyond its output flops.

## Structure
- `snake_pkg` holds:
  - the H/V timing constants, which are used as parameter defaults;
  - the derived totals `H_TOTAL` and `V_TOTAL`;
  - `VGA_CNT_W` = 11, which `vga_if` also uses.
- A single generic sub-module, `mod_counter`, is natural. It takes a parameterised modulus, `en` and `wrap` outputs, and is instantiated twice (H and V), with the H `wrap` gating the V `en`.
- Sync/blank decode and the frame logic stay in the top module.

## Test plan
- Reset, then `pix_en`=1 for 1056 cycles:
  - `hcount` runs 1..1055 then reaches 0, and `vcount` becomes 1;
  - `hblnk` rises at `hcount`=800;
  - `hsync` is high for exactly 128 cycles, starting at 840.
- Run one full frame:
  - `vblnk` rises at `vcount`=600;
  - `vsync` is high for lines 601..604;
  - exactly one `frame_start` pulse occurs, at cycle 663168 after reset release, with `frame_cnt`=1.
- Drive `pix_en` with a 1-in-4 pattern: all line and frame periods scale ×4, outputs hold during disabled cycles, and `frame_start` width is 1 cycle.
- Run 256 frames with `FRAME_CNT_W`=8: `frame_cnt` wraps 255→0 on the 256th `frame_start`.
- Assert `rst` low at `hcount`=500, `vcount`=300, between clock edges: all outputs go to 0 immediately, and counting restarts from 0 after release.
- Alignment checker, every cycle: `hblnk`, `hsync`, `vblnk` and `vsync` match the combinational decode of the same-cycle `hcount`/`vcount`, with zero mismatches over two frames.
